// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the 5-stage MIPS core.
// Holds the 32-bit word type plus the branch predictor's BTB entry and FSM types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default BTB index width (16 entries).
  localparam int BTB_IDX_W = 4;

  // The tag is kept word-wide and zero-extended so the same entry type works
  // for any index width; unused upper tag bits are constant and trim away.
  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    logic [1:0] cnt;
  } btb_entry_t;

  typedef enum logic {
    IDLE,
    PENDING
  } bp_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter2.sv
// 2-bit saturating branch counter: step toward taken (11) or not-taken (00).
module sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  // Saturating increment on taken, saturating decrement on not-taken.
  always_comb begin
    cnt_next = cnt;
    if (taken && (cnt != 2'b11)) begin
      cnt_next = cnt + 2'b01;
    end else if (!taken && (cnt != 2'b00)) begin
      cnt_next = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch-prediction / redirect controller for the 5-stage MIPS pipeline.
// Direct-mapped BTB of 2-bit counters looked up at fetch, updated when BEQ/BNE
// resolve in MEM. A mispredict flushes the pipe and redirects fetch; the
// redirect is held (PENDING) until the PC register accepts it.
// Optional macro BPRED_STATS_EN adds branch / mispredict statistics counters.
module branch_redirect_ctrl
  import cpu_types_pkg::*;
#(
  parameter int         IDX_W    = BTB_IDX_W,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t if_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  stall,
  input  logic  res_valid,
  input  word_t res_pc,
  input  logic  res_taken,
  input  word_t res_target,
  input  logic  res_pred_taken,
  input  word_t res_pred_target,
  input  logic  pc_ready,
  output logic  flush_ID,
  output logic  flush_EX,
  output logic  flush_MEM,
  output logic  redirect_valid,
  output word_t redirect_pc
`ifdef BPRED_STATS_EN
  ,
  output word_t stat_branches,
  output word_t stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  btb_entry_t       btb [ENTRIES];
  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] res_idx;
  word_t            look_tag;
  word_t            res_tag;
  btb_entry_t       look_e;
  btb_entry_t       res_e;
  logic             res_hit;
  logic             resolve;
  logic             mispredict;
  word_t            corrected_pc;
  logic [1:0]       cnt_next;
  bp_state_t        state;
  bp_state_t        state_next;
  word_t            pending_pc;
  word_t            pending_pc_next;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^if_pc[1:0];

  assign look_idx = if_pc[IDX_W+1:2];
  assign look_tag = word_t'(if_pc[31:IDX_W+2]);
  assign res_idx  = res_pc[IDX_W+1:2];
  assign res_tag  = word_t'(res_pc[31:IDX_W+2]);
  assign look_e   = btb[look_idx];
  assign res_e    = btb[res_idx];
  assign res_hit  = res_e.valid && (res_e.tag == res_tag);

  // Zero-latency fetch lookup; reads the pre-update entry (no bypass).
  assign pred_taken  = look_e.valid && (look_e.tag == look_tag) && look_e.cnt[1];
  assign pred_target = pred_taken ? look_e.target : '0;

  // Gating with nRST keeps every output quiet while reset is held.
  assign resolve      = res_valid && !stall && nRST;
  assign mispredict   = (res_taken != res_pred_taken) ||
                        (res_taken && (res_pred_target != res_target));
  assign corrected_pc = res_taken ? res_target : (res_pc + 32'd4);

  sat_counter2 u_sat_counter2 (
    .cnt      (res_e.cnt),
    .taken    (res_taken),
    .cnt_next (cnt_next)
  );

  // BTB update on resolve: train on hit, allocate only on a taken miss.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_INIT};
      end
    end else if (resolve) begin
      if (res_hit) begin
        btb[res_idx].cnt <= cnt_next;
        if (res_taken) begin
          btb[res_idx].target <= res_target;
        end
      end else if (res_taken) begin
        btb[res_idx] <= '{valid: 1'b1, tag: res_tag, target: res_target, cnt: 2'b10};
      end
    end
  end

  // Redirect FSM state and the latched redirect address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      pending_pc <= '0;
    end else begin
      state      <= state_next;
      pending_pc <= pending_pc_next;
    end
  end

  // Flush/redirect outputs and next state; PENDING ignores new resolves and
  // stays put while the pipeline is stalled.
  always_comb begin
    state_next      = state;
    pending_pc_next = pending_pc;
    flush_ID        = 1'b0;
    flush_EX        = 1'b0;
    flush_MEM       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    case (state)
      IDLE: begin
        if (resolve && mispredict) begin
          flush_ID       = 1'b1;
          flush_EX       = 1'b1;
          flush_MEM      = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = corrected_pc;
          if (!pc_ready) begin
            state_next      = PENDING;
            pending_pc_next = corrected_pc;
          end
        end
      end
      PENDING: begin
        flush_ID       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pending_pc;
        if (pc_ready && !stall) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef BPRED_STATS_EN
  // Free-running wrap-around counts of resolves and mispredicts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (resolve) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus a
// randomized run, checked against a behavioural BTB / redirect model.
module tb_branch_redirect_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        pc_ready;
  logic        flush_ID;
  logic        flush_EX;
  logic        flush_MEM;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int num_checks = 0;
  int num_errors = 0;

  // Reference model: 16-entry table, counter as an integer 0..3.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];
  bit          m_pending;
  logic [31:0] m_pend_pc;
  logic [31:0] m_branches;
  logic [31:0] m_mispredicts;

  logic [31:0] pc_pool [6];

  branch_redirect_ctrl dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .stall           (stall),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .pc_ready        (pc_ready),
    .flush_ID        (flush_ID),
    .flush_EX        (flush_EX),
    .flush_MEM       (flush_MEM),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef BPRED_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 32'h0;
      m_cnt[i]    = 1;
    end
    m_pending     = 1'b0;
    m_pend_pc     = 32'h0;
    m_branches    = 32'h0;
    m_mispredicts = 32'h0;
  endtask

  function automatic logic model_pred(input logic [31:0] pc);
    int unsigned idx = (pc / 4) % 16;
    return m_valid[idx] && (m_tag[idx] == (pc / 64)) && (m_cnt[idx] >= 2);
  endfunction

  function automatic logic model_mis();
    return (res_taken != res_pred_taken) || (res_taken && (res_pred_target != res_target));
  endfunction

  function automatic logic [31:0] model_corr();
    logic [31:0] next_seq = res_pc + 32'd4;
    return res_taken ? res_target : next_seq;
  endfunction

  // Compare every output against what the model says for the current inputs.
  task automatic checkOutput();
    int unsigned idx = (if_pc / 4) % 16;
    logic        ev  = res_valid && !stall && nRST;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_fid, e_fex, e_rv;
    logic [31:0] e_rpc;
    e_pt   = model_pred(if_pc);
    e_ptgt = e_pt ? m_target[idx] : 32'h0;
    e_fid = 1'b0; e_fex = 1'b0; e_rv = 1'b0; e_rpc = 32'h0;
    if (m_pending) begin
      e_fid = 1'b1; e_rv = 1'b1; e_rpc = m_pend_pc;
    end else if (ev && model_mis()) begin
      e_fid = 1'b1; e_fex = 1'b1; e_rv = 1'b1; e_rpc = model_corr();
    end
    chk("pred_taken", 32'(pred_taken), 32'(e_pt));
    chk("pred_target", pred_target, e_ptgt);
    chk("flush_ID", 32'(flush_ID), 32'(e_fid));
    chk("flush_EX", 32'(flush_EX), 32'(e_fex));
    chk("flush_MEM", 32'(flush_MEM), 32'(e_fex));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_pc", redirect_pc, e_rpc);
`ifdef BPRED_STATS_EN
    chk("stat_branches", stat_branches, m_branches);
    chk("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic modelUpdate();
    int unsigned idx = (res_pc / 4) % 16;
    int unsigned tag = res_pc / 64;
    logic        ev  = res_valid && !stall;
    logic        mis = model_mis();
    logic [31:0] corr = model_corr();
    if (!nRST) begin
      modelReset();
      return;
    end
    if (m_pending) begin
      if (pc_ready && !stall) m_pending = 1'b0;
    end else if (ev && mis && !pc_ready) begin
      m_pending = 1'b1;
      m_pend_pc = corr;
    end
    if (ev) begin
      m_branches = m_branches + 32'd1;
      if (mis) m_mispredicts = m_mispredicts + 32'd1;
      if (m_valid[idx] && m_tag[idx] == tag) begin
        m_cnt[idx] = res_taken ? ((m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3)
                               : ((m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0);
        if (res_taken) m_target[idx] = res_target;
      end else if (res_taken) begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = tag;
        m_target[idx] = res_target;
        m_cnt[idx]    = 2;
      end
    end
  endtask

  task automatic setRes(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ppt, input logic [31:0] pptgt);
    res_valid       = v;
    res_pc          = pc;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ppt;
    res_pred_target = pptgt;
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit later.
  task automatic applyStimulus();
    #1;
    checkOutput();
  endtask

  task automatic advance();
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  initial begin
    pc_pool[0] = 32'h0000_0040; pc_pool[1] = 32'h0000_0044;
    pc_pool[2] = 32'h0000_0080; pc_pool[3] = 32'h0000_0440;
    pc_pool[4] = 32'h0000_1000; pc_pool[5] = 32'hFFFF_FFFC;
    nRST = 1'b0; stall = 1'b0; pc_ready = 1'b1; if_pc = 32'h40;
    setRes(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    modelReset();
    repeat (2) @(negedge CLK);
    applyStimulus();
    nRST = 1'b1;
    $display("[TB] reset released");

    // Empty BTB, nothing resolving.
    applyStimulus();
    chk("tp_reset_pred", 32'(pred_taken), 32'h0);
    advance();

    // First taken resolve at 0x40 mispredicts and allocates.
    setRes(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    applyStimulus();
    chk("tp_alloc_redirect", redirect_pc, 32'h80);
    advance();
    setRes(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus();
    chk("tp_alloc_pred_target", pred_target, 32'h80);
    advance();

    // Two correctly predicted taken resolves, then three not-taken.
    repeat (2) begin
      setRes(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      applyStimulus();
      advance();
    end
    setRes(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    applyStimulus();
    chk("tp_nt_redirect", redirect_pc, 32'h44);
    advance();
    applyStimulus();
    advance();
    setRes(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus();
    chk("tp_nt_pred_off", 32'(pred_taken), 32'h0);
    advance();
    setRes(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus();
    advance();

    // Mispredict held for three cycles without pc_ready.
    setRes(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    pc_ready = 1'b0;
    applyStimulus();
    advance();
    setRes(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) begin
      applyStimulus();
      chk("tp_hold_flush_EX", 32'(flush_EX), 32'h0);
      advance();
    end
    pc_ready = 1'b1;
    applyStimulus();
    chk("tp_hold_redirect_pc", redirect_pc, 32'h200);
    advance();
    applyStimulus();
    chk("tp_hold_released", 32'(redirect_valid), 32'h0);
    advance();

    // Stalled resolve is ignored.
    stall = 1'b1;
    if_pc = 32'h48;
    setRes(1'b1, 32'h48, 1'b1, 32'h300, 1'b0, 32'h0);
    applyStimulus();
    chk("tp_stall_flush", 32'(flush_ID), 32'h0);
    advance();
    stall = 1'b0;
    setRes(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus();
    chk("tp_stall_no_alloc", 32'(pred_taken), 32'h0);
    advance();

    // Fall-through address wraps at the top of the address space.
    setRes(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    applyStimulus();
    chk("tp_wrap_valid", 32'(redirect_valid), 32'h1);
    chk("tp_wrap_pc", redirect_pc, 32'h0);
    advance();

    // Randomized traffic over a small pool of aliasing addresses.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc, tgt;
      logic        tk, ppt;
      rpc = pc_pool[$urandom_range(0, 5)];
      tgt = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                        : pc_pool[$urandom_range(0, 5)];
      tk  = 1'($urandom_range(0, 1));
      ppt = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : model_pred(rpc);
      if_pc    = ($urandom_range(0, 4) == 0) ? rpc : pc_pool[$urandom_range(0, 5)];
      stall    = ($urandom_range(0, 4) == 0);
      pc_ready = ($urandom_range(0, 4) != 0);
      setRes(1'($urandom_range(0, 1)), rpc, tk, tgt, ppt,
             ppt ? (($urandom_range(0, 3) == 0) ? pc_pool[$urandom_range(0, 5)] : tgt) : 32'h0);
      applyStimulus();
      advance();
    end

    // Asynchronous reset while a redirect is pending.
    stall = 1'b0; pc_ready = 1'b1; if_pc = 32'h40;
    setRes(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    applyStimulus();
    advance();
    setRes(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    pc_ready = 1'b0;
    applyStimulus();
    advance();
    applyStimulus();
    chk("tp_rst_pre_pending", 32'(redirect_valid), 32'h1);
    #1;
    nRST = 1'b0;
    modelReset();
    #1;
    checkOutput();
    chk("tp_rst_async_rv", 32'(redirect_valid), 32'h0);
    chk("tp_rst_async_pred", 32'(pred_taken), 32'h0);
    advance();
    nRST = 1'b1;
    pc_ready = 1'b1;
    setRes(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus();
    chk("tp_rst_no_flush", 32'(flush_ID), 32'h0);
    chk("tp_rst_btb_empty", 32'(pred_taken), 32'h0);
`ifdef BPRED_STATS_EN
    chk("tp_rst_stats", stat_branches | stat_mispredicts, 32'h0);
`endif
    advance();

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
